// File: rtl/if_prefetch.sv
`timescale 1ns/1ps
// Instruction prefetcher: up to MAX_OUTST inst_sram reads in flight, returns queued in an IBUF_DEPTH buffer.
// A word reaches decode no earlier than the cycle after data_ok; fetch stalls on buffer credit, ds_allowin pops the head.
module if_prefetch #(
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter int          MAX_OUTST  = 2,
    parameter int          IBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fs_to_ds_valid,
    output logic [64:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int BW = $clog2(IBUF_DEPTH + 1);
    localparam int SW = BW + 1;
    localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_pending_cnt;
    logic [CW-1:0] r_discard_cnt;
    logic [31:0]   r_pcq [MAX_OUTST];
    logic [QW-1:0] r_pcq_wr;
    logic [QW-1:0] r_pcq_rd;
    logic [64:0]   r_ibuf [IBUF_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [BW-1:0] r_count;
    logic          r_adel_stop;

    logic          w_aligned;
    logic          w_credit_ok;
    logic          w_fetch_ok;
    logic          w_adel_wr;
    logic          w_hs;
    logic          w_data_wr;
    logic          w_push;
    logic          w_pop;
    logic [64:0]   w_push_dat;
    logic [QW-1:0] w_pcq_wr_nxt;
    logic [QW-1:0] w_pcq_rd_nxt;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_rd_ptr_nxt;

    // Credit covers both buffered words and words still in flight, so a return always has a slot.
    assign w_aligned   = (r_fetch_pc[1:0] == 2'b00);
    assign w_credit_ok = (SW'(r_pending_cnt) + SW'(r_count)) < SW'(IBUF_DEPTH);
    assign w_fetch_ok  = resetn & ~redirect_valid & ~r_adel_stop & w_credit_ok;
    assign w_adel_wr   = w_fetch_ok & ~w_aligned & (r_pending_cnt == '0);
    assign w_hs        = inst_sram_req & inst_sram_addr_ok;
    assign w_data_wr   = inst_sram_data_ok & (r_discard_cnt == '0) & ~redirect_valid;
    assign w_push      = w_data_wr | w_adel_wr;
    assign w_pop       = fs_to_ds_valid & ds_allowin;
    assign w_push_dat  = w_adel_wr ? {1'b1, 32'h0, r_fetch_pc}
                                   : {1'b0, inst_sram_rdata, r_pcq[r_pcq_rd]};

    assign w_pcq_wr_nxt = (r_pcq_wr == QW'(MAX_OUTST - 1)) ? '0 : r_pcq_wr + QW'(1);
    assign w_pcq_rd_nxt = (r_pcq_rd == QW'(MAX_OUTST - 1)) ? '0 : r_pcq_rd + QW'(1);
    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(IBUF_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(IBUF_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

    assign inst_sram_req   = w_fetch_ok & w_aligned & (r_pending_cnt < CW'(MAX_OUTST));
    assign inst_sram_addr  = {r_fetch_pc[31:2], 2'b00};
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;
    assign fs_to_ds_valid  = (r_count != '0);
    assign fs_to_ds_bus    = r_ibuf[r_rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fetch_pc    <= RESET_PC;
            r_pending_cnt <= '0;
            r_discard_cnt <= '0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_adel_stop   <= 1'b0;
        end else begin
            r_pending_cnt <= r_pending_cnt + CW'(w_hs) - CW'(inst_sram_data_ok);
            if (w_hs)
                r_pcq_wr <= w_pcq_wr_nxt;
            if (inst_sram_data_ok)
                r_pcq_rd <= w_pcq_rd_nxt;
            if (redirect_valid) begin
                r_fetch_pc    <= redirect_pc;
                // Every request still in flight after this edge belongs to the abandoned stream.
                r_discard_cnt <= r_pending_cnt + CW'(w_hs) - CW'(inst_sram_data_ok);
                r_adel_stop   <= 1'b0;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_count       <= '0;
            end else begin
                if (w_hs)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (inst_sram_data_ok && (r_discard_cnt != '0))
                    r_discard_cnt <= r_discard_cnt - CW'(1);
                if (w_adel_wr)
                    r_adel_stop <= 1'b1;
                if (w_push)
                    r_wr_ptr <= w_wr_ptr_nxt;
                if (w_pop)
                    r_rd_ptr <= w_rd_ptr_nxt;
                r_count <= r_count + BW'(w_push) - BW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs)
            r_pcq[r_pcq_wr] <= r_fetch_pc;
        if (w_push)
            r_ibuf[r_wr_ptr] <= w_push_dat;
    end

endmodule

// File: tb/tb_if_prefetch.sv
`timescale 1ns/1ps
// Bench for if_prefetch: randomized memory slave and decode stage, queue-based reference of the fetch stream.
module tb_if_prefetch;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam int MAXO  = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ds_allowin;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    if_prefetch #(.RESET_PC(RESET_PC), .MAX_OUTST(MAXO), .IBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int k_allow = 0, k_aok = 100, k_lat_lo = 1, k_lat_hi = 1;
    bit redir_pend = 0;
    logic [31:0] redir_pc_pend = '0;
    bit arm_redir_dok = 0, arm_fired = 0;
    logic [31:0] arm_pc = '0;

    logic [31:0] sq_addr[$];
    int          sq_rdy[$];

    logic [31:0] m_fpc = RESET_PC;
    bit          m_stop = 0;
    logic [31:0] mo_pc[$];
    bit          mo_stale[$];
    logic [64:0] mq[$];
    logic [64:0] dlog[$];
    int m_max_cnt = 0, m_hs_total = 0, m_drop_stale = 0, m_drop_redir = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h5a5a0f0f;
    endfunction

    // Drives all inputs for one cycle at the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        redirect_valid    = redir_pend;
        redirect_pc       = redir_pc_pend;
        redir_pend        = 0;
        ds_allowin        = ($urandom_range(99) < k_allow);
        inst_sram_addr_ok = ($urandom_range(99) < k_aok);
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = $urandom;
        if (sq_addr.size() > 0 && sq_rdy[0] <= cyc) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = mem_word(sq_addr[0]);
            if (arm_redir_dok && sq_addr.size() == 2) begin
                redirect_valid = 1'b1;
                redirect_pc    = arm_pc;
                arm_redir_dok  = 0;
                arm_fired      = 1;
            end
            void'(sq_addr.pop_front());
            void'(sq_rdy.pop_front());
        end
    endtask

    // Reference: expected stream, outstanding requests and buffer contents from the fetch rules.
    always @(negedge clk) begin
        bit e_req, e_adel, hs, dok, pop, redir, st;
        logic [31:0] pc;
        #2;
        if (!resetn) begin
            checks++;
            if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold req=%b valid=%b required 0/0", inst_sram_req, fs_to_ds_valid);
            end
            m_fpc = RESET_PC; m_stop = 0;
            mo_pc.delete(); mo_stale.delete(); mq.delete(); sq_addr.delete(); sq_rdy.delete();
        end else begin
            e_req = !redirect_valid && !m_stop && (m_fpc[1:0] == 2'b00) &&
                    (mo_pc.size() < MAXO) && (mo_pc.size() + mq.size() < DEPTH);
            e_adel = !redirect_valid && !m_stop && (m_fpc[1:0] != 2'b00) &&
                     (mo_pc.size() == 0) && (mq.size() < DEPTH);
            checks++;
            if (inst_sram_req !== e_req) begin
                errors++;
                $display("FAIL req cyc=%0d got %b required %b", cyc, inst_sram_req, e_req);
            end
            if (e_req) begin
                checks++;
                if (inst_sram_addr !== m_fpc) begin
                    errors++;
                    $display("FAIL addr cyc=%0d got %h required %h", cyc, inst_sram_addr, m_fpc);
                end
            end
            checks++;
            if (fs_to_ds_valid !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL valid cyc=%0d got %b required %b", cyc, fs_to_ds_valid, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                checks++;
                if (fs_to_ds_bus !== mq[0]) begin
                    errors++;
                    $display("FAIL bus cyc=%0d got %h required %h", cyc, fs_to_ds_bus, mq[0]);
                end
            end
            hs    = inst_sram_req && inst_sram_addr_ok;
            dok   = inst_sram_data_ok;
            pop   = fs_to_ds_valid && ds_allowin;
            redir = redirect_valid;
            if (pop) begin
                dlog.push_back(fs_to_ds_bus);
                if (mq.size() > 0) void'(mq.pop_front());
            end
            if (dok && mo_pc.size() > 0) begin
                pc = mo_pc.pop_front();
                st = mo_stale.pop_front();
                if (st) m_drop_stale++;
                else if (redir) m_drop_redir++;
                else mq.push_back({1'b0, mem_word(pc), pc});
            end
            if (hs) begin
                mo_pc.push_back(m_fpc);
                mo_stale.push_back(1'b0);
                sq_addr.push_back(inst_sram_addr);
                sq_rdy.push_back(cyc + int'($urandom_range(k_lat_hi, k_lat_lo)));
                m_fpc = m_fpc + 32'd4;
                m_hs_total++;
            end
            if (redir) begin
                foreach (mo_stale[i]) mo_stale[i] = 1'b1;
                mq.delete();
                m_fpc  = redirect_pc;
                m_stop = 0;
            end else if (e_adel) begin
                mq.push_back({1'b1, 32'h0, m_fpc});
                m_stop = 1;
            end
            if (mq.size() > m_max_cnt) m_max_cnt = mq.size();
        end
    end

    task automatic test_reset();
        resetn = 1'b0; ds_allowin = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
        repeat (3) tick();
        #3;
        checks++;
        if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b required 0", inst_sram_req); end
        checks++;
        if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b required 0", fs_to_ds_valid); end
        checks++;
        if (inst_sram_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr got %h required %h", inst_sram_addr, RESET_PC); end
        checks++;
        if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
            errors++;
            $display("FAIL const_outs got wr=%b size=%b wstrb=%h wdata=%h required 0/10/0/0",
                     inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
        end
        tick();
        #1 resetn = 1'b1;
        #1;
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req got req=%b addr=%h required 1/%h", inst_sram_req, inst_sram_addr, RESET_PC);
        end
        dlog.delete();
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        k_allow = 100; k_aok = 100; k_lat_lo = 1; k_lat_hi = 1;
        repeat (40) tick();
        #3;
        checks++;
        if (dlog.size() < 38) begin errors++; $display("FAIL stream_rate got %0d required >=38", dlog.size()); end
        for (int i = 0; i < dlog.size(); i++) begin
            pc = RESET_PC + 32'(4 * i);
            checks++;
            if (dlog[i] !== {1'b0, mem_word(pc), pc}) begin
                errors++;
                $display("FAIL stream_word[%0d] got %h required %h", i, dlog[i], {1'b0, mem_word(pc), pc});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] last_pc;
        last_pc = (dlog.size() > 0) ? dlog[dlog.size() - 1][31:0] : RESET_PC - 32'd4;
        dlog.delete();
        m_max_cnt = 0;
        k_allow = 0;
        repeat (20) tick();
        #3;
        checks++;
        if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall got req=%b valid=%b required 0/1", inst_sram_req, fs_to_ds_valid);
        end
        checks++;
        if (m_max_cnt != DEPTH || sq_addr.size() != 0) begin
            errors++;
            $display("FAIL bp_fill got occ=%0d outst=%0d required %0d/0", m_max_cnt, sq_addr.size(), DEPTH);
        end
        k_allow = 100;
        repeat (30) tick();
        #3;
        checks++;
        if (dlog.size() < 20) begin errors++; $display("FAIL bp_drain_cnt got %0d required >=20", dlog.size()); end
        for (int i = 0; i < dlog.size(); i++) begin
            checks++;
            if (dlog[i][31:0] !== last_pc + 32'(4 * (i + 1))) begin
                errors++;
                $display("FAIL bp_order[%0d] got %h required %h", i, dlog[i][31:0], last_pc + 32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_redirect();
        int n = 0;
        int snap;
        k_allow = 100; k_aok = 0;
        repeat (12) tick();
        k_aok = 100; k_lat_lo = 6; k_lat_hi = 6;
        while (sq_addr.size() != 2 && n < 40) begin tick(); #3; n++; end
        checks++;
        if (sq_addr.size() != 2) begin errors++; $display("FAIL redir_setup outst=%0d required 2", sq_addr.size()); end
        snap = m_drop_stale;
        redir_pend = 1; redir_pc_pend = 32'hbfc00380;
        tick(); #3;
        dlog.delete();
        k_lat_lo = 1; k_lat_hi = 1;
        repeat (25) tick();
        #3;
        checks++;
        if (m_drop_stale - snap != 2) begin errors++; $display("FAIL redir_drops got %0d required 2", m_drop_stale - snap); end
        checks++;
        if (dlog.size() < 2 || dlog[0] !== {1'b0, mem_word(32'hbfc00380), 32'hbfc00380} ||
            dlog[1][31:0] !== 32'hbfc00384) begin
            errors++;
            $display("FAIL redir_first got n=%0d head=%h required head pc bfc00380 then bfc00384",
                     dlog.size(), (dlog.size() > 0) ? dlog[0] : 65'h0);
        end
    endtask

    task automatic test_redirect_dataok();
        int n = 0;
        int s_stale, s_redir;
        k_aok = 0;
        repeat (12) tick();
        s_stale = m_drop_stale; s_redir = m_drop_redir;
        k_aok = 100; k_lat_lo = 3; k_lat_hi = 3;
        arm_pc = 32'hbfc01000; arm_fired = 0; arm_redir_dok = 1;
        while (!arm_fired && n < 50) begin tick(); n++; end
        arm_redir_dok = 0;
        #3;
        dlog.delete();
        checks++;
        if (!arm_fired) begin errors++; $display("FAIL rdok_setup got fired=0 required 1"); end
        k_lat_lo = 1; k_lat_hi = 1;
        repeat (20) tick();
        #3;
        checks++;
        if (m_drop_redir - s_redir != 1 || m_drop_stale - s_stale != 1) begin
            errors++;
            $display("FAIL rdok_drops got same_cycle=%0d later=%0d required 1/1",
                     m_drop_redir - s_redir, m_drop_stale - s_stale);
        end
        checks++;
        if (dlog.size() == 0 || dlog[0] !== {1'b0, mem_word(32'hbfc01000), 32'hbfc01000}) begin
            errors++;
            $display("FAIL rdok_first got %h required %h", (dlog.size() > 0) ? dlog[0] : 65'h0,
                     {1'b0, mem_word(32'hbfc01000), 32'hbfc01000});
        end
    endtask

    task automatic test_adel();
        int snap;
        redir_pend = 1; redir_pc_pend = 32'h80000002;
        tick(); #3;
        dlog.delete();
        snap = m_hs_total;
        repeat (15) tick();
        #3;
        checks++;
        if (m_hs_total != snap) begin errors++; $display("FAIL adel_noreq got %0d requests required 0", m_hs_total - snap); end
        checks++;
        if (dlog.size() != 1 || dlog[0] !== {1'b1, 32'h0, 32'h80000002}) begin
            errors++;
            $display("FAIL adel_entry got n=%0d head=%h required 1 entry %h", dlog.size(),
                     (dlog.size() > 0) ? dlog[0] : 65'h0, {1'b1, 32'h0, 32'h80000002});
        end
        redir_pend = 1; redir_pc_pend = 32'h80000000;
        tick(); #3;
        dlog.delete();
        repeat (15) tick();
        #3;
        checks++;
        if (dlog.size() < 10 || dlog[0] !== {1'b0, mem_word(32'h80000000), 32'h80000000}) begin
            errors++;
            $display("FAIL adel_resume got n=%0d head=%h required >=10 from 80000000", dlog.size(),
                     (dlog.size() > 0) ? dlog[0] : 65'h0);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pc;
        redir_pend = 1; redir_pc_pend = 32'hfffffff8;
        tick(); #3;
        dlog.delete();
        repeat (15) tick();
        #3;
        checks++;
        if (dlog.size() < 3) begin errors++; $display("FAIL wrap_cnt got %0d required >=3", dlog.size()); end
        for (int i = 0; i < 3 && i < dlog.size(); i++) begin
            pc = 32'hfffffff8 + 32'(4 * i);
            checks++;
            if (dlog[i] !== {1'b0, mem_word(pc), pc}) begin
                errors++;
                $display("FAIL wrap_word[%0d] got %h required %h", i, dlog[i], {1'b0, mem_word(pc), pc});
            end
        end
    endtask

    task automatic test_random();
        int snap;
        logic [31:0] pc;
        snap = m_hs_total;
        dlog.delete();
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) begin
                k_allow  = $urandom_range(100);
                k_aok    = $urandom_range(100, 30);
                k_lat_lo = 1;
                k_lat_hi = $urandom_range(4, 1);
            end
            if ($urandom_range(99) < 3) begin
                pc = $urandom;
                if ($urandom_range(7) != 0) pc[1:0] = 2'b00;
                redir_pend = 1; redir_pc_pend = pc;
            end
            tick();
            #3;
            checks++;
            if (sq_addr.size() > MAXO) begin
                errors++;
                $display("FAIL rnd_outst cyc=%0d got %0d required <=%0d", cyc, sq_addr.size(), MAXO);
            end
        end
        checks++;
        if (m_hs_total == snap || dlog.size() == 0) begin
            errors++;
            $display("FAIL rnd_progress got req=%0d deliv=%0d required both >0", m_hs_total - snap, dlog.size());
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        redir_pend = 1; redir_pc_pend = 32'h00001000;
        k_allow = 0; k_aok = 100; k_lat_lo = 8; k_lat_hi = 8;
        tick(); #3;
        while (!(mq.size() == 2 && sq_addr.size() == 2) && n < 60) begin tick(); #3; n++; end
        checks++;
        if (!(mq.size() == 2 && sq_addr.size() == 2)) begin
            errors++;
            $display("FAIL rmid_setup got buf=%0d outst=%0d required 2/2", mq.size(), sq_addr.size());
        end
        resetn = 1'b0;
        sq_addr.delete(); sq_rdy.delete();
        inst_sram_data_ok = 1'b0; redirect_valid = 1'b0;
        #1;
        checks++;
        if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0 || inst_sram_addr !== RESET_PC) begin
            errors++;
            $display("FAIL rmid_async got req=%b valid=%b addr=%h required 0/0/%h",
                     inst_sram_req, fs_to_ds_valid, inst_sram_addr, RESET_PC);
        end
        repeat (2) tick();
        #1 resetn = 1'b1;
        #1;
        checks++;
        if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC) begin
            errors++;
            $display("FAIL rmid_restart got req=%b addr=%h required 1/%h", inst_sram_req, inst_sram_addr, RESET_PC);
        end
        dlog.delete();
        k_allow = 100; k_lat_lo = 1; k_lat_hi = 1;
        repeat (15) tick();
        #3;
        checks++;
        if (dlog.size() == 0 || dlog[0] !== {1'b0, mem_word(RESET_PC), RESET_PC}) begin
            errors++;
            $display("FAIL rmid_first got %h required %h", (dlog.size() > 0) ? dlog[0] : 65'h0,
                     {1'b0, mem_word(RESET_PC), RESET_PC});
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_dataok();
        test_adel();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
